ula_muldiv: RTL and testbench
=============================

// Module: ula_muldiv
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit that sits alongside the datapath ALU.
//  Executes MIPS MULT/MULTU/DIV/DIVU into internal HI/LO registers and services MTHI/MTLO.
//  Operations use a start/busy/done handshake. The control unit stalls the core while busy=1.
//  HI/LO are read by the MFHI/MFLO datapath mux.
// PARAMETERS
//  WIDTH  32  operand, HI and LO width in bits; must be >= 4
//  CNT_W  $clog2(WIDTH+1)  iteration counter width (derived; do not override)
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only while busy=0
//  op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  a      in   WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
//  b      in   WIDTH  rt operand: multiplier or divisor
//  hi     out  WIDTH  HI register: product upper half or remainder
//  lo     out  WIDTH  LO register: product lower half or quotient
//  busy   out  1      1 while a MULT/DIV operation is in flight
//  done   out  1      one-cycle pulse; the new HI/LO values are valid
// BEHAVIOUR
//  Reset: asynchronous and active-high. hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
//   Reset mid-operation aborts the operation. No done pulse is produced.
//  States: IDLE -> RUN -> FIX -> IDLE.
//  IDLE:
//   - start=1 with op MULT..DIVU: latch a, b and op. For signed ops, store magnitudes and result signs.
//     Set counter=WIDTH, busy=1, go to RUN.
//   - start=1 with op MTHI or MTLO: write a into hi or lo at that edge. Stay in IDLE, no busy, no done.
//   - start=1 with op 110 or 111: ignored.
//  RUN: one iteration per cycle; counter decrements; go to FIX after the WIDTH-th iteration.
//   - Multiply: shift-add over a 2*WIDTH accumulator.
//   - Divide: restoring shift-subtract (quotient, remainder).
//  FIX: apply two's-complement sign correction.
//   - Signed MULT: negate the 2*WIDTH product if the operand signs differ.
//   - Signed DIV: quotient is negative if the signs differ; remainder takes the dividend's sign.
//   - Write hi and lo. busy=0 and done=1 in the following cycle, then return to IDLE.
//  Latency: start accepted at edge 0; hi, lo and done update at edge WIDTH+1.
//   busy is high for cycles 1..WIDTH+1. A new start is accepted at edge WIDTH+2 or later.
//  done is high for exactly one cycle.
//   start in the cycle done=1 is legal: it is accepted because busy=0.
//  start while busy=1 is ignored: no queueing, and hi/lo are not disturbed.
//  a and b may change after acceptance; operands are latched internally.
//  hi and lo hold their values between operations.
//   Their intermediate values are never visible while busy=1; the old values are held.
//  Divide by zero (b=0, DIV or DIVU): full normal latency.
//   Result lo = all ones, hi = a (raw dividend). No exception is raised.
//  Signed overflow (a=MIN, b=-1, DIV): lo = MIN, hi = 0, from two's-complement wrap.
//  MULT/MULTU produce the exact 2*WIDTH product and never overflow.
// TESTING (WIDTH=32)
//  MULT a=FFFFFFFD, b=00000005 -> after 33 busy cycles: done=1, hi=FFFFFFFF, lo=FFFFFFF1.
//  MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Repeat as MULT -> hi=00000000, lo=00000001.
//  DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//   DIVU same operands -> lo=7FFFFFFC, hi=00000001.
//  DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678.
//   DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  MTHI a=CAFEBABE: hi updates next edge, busy stays 0, done stays 0.
//   Then start DIV, and pulse start with MTLO at cycle 5 -> ignored; lo is the quotient only.
//  Assert reset at cycle 10 of a MULT -> hi=lo=0 and busy=0 immediately; no done pulse.
//   start at the next edge is accepted normally.

Source files
------------

// File: rtl/ula_muldiv_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// The master drives the request; the slave returns HI/LO and the busy/done status.
interface ula_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input hi, lo, busy, done);
  modport slave  (input start, op, a, b, output hi, lo, busy, done);
endinterface

// File: rtl/ula_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  ula_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 done_r;

  logic                 is_div, neg_q, neg_r;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;

  logic                 accept, mt_hi, mt_lo;
  logic                 signed_op, a_neg, b_neg, neg_q_in;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]     a_mag, b_mag;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Request decode: only sampled while idle, so starts during busy are dropped.
  assign accept    = (state == IDLE) && bus.start && !bus.op[2];
  assign mt_hi     = (state == IDLE) && bus.start && (bus.op == 3'b100);
  assign mt_lo     = (state == IDLE) && bus.start && (bus.op == 3'b101);
  assign signed_op = !bus.op[0];
  assign a_s       = bus.a;
  assign b_s       = bus.b;
  assign a_neg     = signed_op && (a_s < 0);
  assign b_neg     = signed_op && (b_s < 0);
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  // A zero divisor must leave the all-ones quotient unnegated.
  assign neg_q_in  = (a_neg ^ b_neg) && (!bus.op[1] || (bus.b != '0));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration step: multiply adds into the upper half then shifts right,
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, rem_sh} - {2'b00, mcand};
    div_ge   = !div_diff[WIDTH+1];
    div_nxt  = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    prod_fix = neg_2w(acc, neg_q);
    quo_fix  = neg_w(acc[WIDTH-1:0], neg_q);
    rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
  end

  // Operand latch and iteration accumulator.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= bus.op[1];
      neg_q  <= neg_q_in;
      neg_r  <= a_neg;
      mcand  <= bus.op[1] ? b_mag : a_mag;
      acc    <= bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
    end else if (state == RUN) begin
      acc    <= is_div ? div_nxt : mul_nxt;
    end
  end

  // Control and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == FIX);
      if (accept)
        cnt <= CNT_W'(WIDTH);
      else if (state == RUN)
        cnt <= cnt - CNT_W'(1);
      if (state == FIX) begin
        if (is_div) begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end else begin
          hi_r <= prod_fix[2*WIDTH-1:WIDTH];
          lo_r <= prod_fix[WIDTH-1:0];
        end
      end else begin
        if (mt_hi) hi_r <= bus.a;
        if (mt_lo) lo_r <= bus.a;
      end
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
endmodule

// File: tb/tb_ula_muldiv.sv
// Directed-vector bench for ula_muldiv at WIDTH=32.
module tb_ula_muldiv;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  ula_muldiv_if #(.WIDTH(32)) bus ();

  ula_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int mt_at, output int bcnt, output bit ok, output bit held);
    logic [31:0] h0, l0;
    int lat;
    h0 = bus.hi; l0 = bus.lo; held = 1'b1; bcnt = 0; lat = 0;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
      if (lat == mt_at) begin
        bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'hDEADBEEF;
      end
      if (bus.busy) begin
        bcnt++;
        if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
      end
    end while (!bus.done && lat < 100);
    ok = bus.done;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int bc; bit ok, held;
    run_op(3'b000, 32'hFFFFFFFD, 32'h00000005, -1, bc, ok, held);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mult_done: got %b want 1", ok); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL mult_hold_while_busy: got %b want 1", held); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFFFFF1); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_at_done: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mult_done_width: got %b want 0", bus.done); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo_held: got %h want %h", bus.lo, 32'hFFFFFFF1); end
  endtask

  task automatic test_mult_allones;
    int bc; bit ok, held;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, bc, ok, held);
    n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h want %h", bus.hi, 32'hFFFFFFFE); end
    n_cmp++; if (bus.lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h want %h", bus.lo, 32'h00000001); end
    @(negedge clk);
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, bc, ok, held);
    n_cmp++; if (bus.hi !== 32'h00000000) begin n_err++; $display("FAIL mults_hi: got %h want %h", bus.hi, 32'h00000000); end
    n_cmp++; if (bus.lo !== 32'h00000001) begin n_err++; $display("FAIL mults_lo: got %h want %h", bus.lo, 32'h00000001); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int bc; bit ok, held;
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, -1, bc, ok, held);
    n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h want %h", bus.lo, 32'hFFFFFFFD); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    @(negedge clk);
    run_op(3'b011, 32'hFFFFFFF9, 32'h00000002, -1, bc, ok, held);
    n_cmp++; if (bus.lo !== 32'h7FFFFFFC) begin n_err++; $display("FAIL divu_lo: got %h want %h", bus.lo, 32'h7FFFFFFC); end
    n_cmp++; if (bus.hi !== 32'h00000001) begin n_err++; $display("FAIL divu_hi: got %h want %h", bus.hi, 32'h00000001); end
    @(negedge clk);
  endtask

  task automatic test_div_corners;
    int bc; bit ok, held;
    run_op(3'b011, 32'h12345678, 32'h00000000, -1, bc, ok, held);
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL divzero_busy_cycles: got %0d want 33", bc); end
    n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divzero_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); end
    n_cmp++; if (bus.hi !== 32'h12345678) begin n_err++; $display("FAIL divzero_hi: got %h want %h", bus.hi, 32'h12345678); end
    @(negedge clk);
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000000, -1, bc, ok, held);
    n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sdivzero_lo: got %h want %h", bus.lo, 32'hFFFFFFFF); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFF9) begin n_err++; $display("FAIL sdivzero_hi: got %h want %h", bus.hi, 32'hFFFFFFF9); end
    @(negedge clk);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, -1, bc, ok, held);
    n_cmp++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo: got %h want %h", bus.lo, 32'h80000000); end
    n_cmp++; if (bus.hi !== 32'h00000000) begin n_err++; $display("FAIL divovf_hi: got %h want %h", bus.hi, 32'h00000000); end
    @(negedge clk);
  endtask

  task automatic test_mt;
    int bc; bit ok, held;
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hCAFEBABE;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.hi !== 32'hCAFEBABE) begin n_err++; $display("FAIL mthi_hi: got %h want %h", bus.hi, 32'hCAFEBABE); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mthi_done: got %b want 0", bus.done); end
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h0BADF00D;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.lo !== 32'h0BADF00D) begin n_err++; $display("FAIL mtlo_lo: got %h want %h", bus.lo, 32'h0BADF00D); end
    n_cmp++; if (bus.hi !== 32'hCAFEBABE) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want %h", bus.hi, 32'hCAFEBABE); end
    // 100 / 7 = 14 r 2, with an MTLO attempted while busy
    run_op(3'b010, 32'd100, 32'd7, 5, bc, ok, held);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mtlo_busy_done: got %b want 1", ok); end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL mtlo_busy_hold: got %b want 1", held); end
    n_cmp++; if (bus.lo !== 32'h0000000E) begin n_err++; $display("FAIL mtlo_busy_lo: got %h want %h", bus.lo, 32'h0000000E); end
    n_cmp++; if (bus.hi !== 32'h00000002) begin n_err++; $display("FAIL mtlo_busy_hi: got %h want %h", bus.hi, 32'h00000002); end
  endtask

  task automatic test_back_to_back;
    int bc; bit ok, held;
    run_op(3'b001, 32'd3, 32'd4, -1, bc, ok, held);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", ok); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 33", bc); end
    n_cmp++; if (bus.lo !== 32'h0000000C) begin n_err++; $display("FAIL b2b_lo: got %h want %h", bus.lo, 32'h0000000C); end
    n_cmp++; if (bus.hi !== 32'h00000000) begin n_err++; $display("FAIL b2b_hi: got %h want %h", bus.hi, 32'h00000000); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int bc; bit ok, held;
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'hFFFF0000; bus.b = 32'h00010000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi: got %h want %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo: got %h want %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    @(negedge clk);
    reset = 1'b0;
    run_op(3'b001, 32'd6, 32'd7, -1, bc, ok, held);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_next_done: got %b want 1", ok); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL rstmid_next_cycles: got %0d want 33", bc); end
    n_cmp++; if (bus.lo !== 32'd42) begin n_err++; $display("FAIL rstmid_next_lo: got %h want %h", bus.lo, 32'd42); end
    n_cmp++; if (bus.hi !== 32'd0) begin n_err++; $display("FAIL rstmid_next_hi: got %h want %h", bus.hi, 32'd0); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_mult_allones();
    test_div();
    test_div_corners();
    test_mt();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
